// File: rtl/mmio_slot_master.sv
// Single initiator of the MMIO slot bus: takes one CPU load/store, drives the decoded slot
// until it reports done/error (or times out), then hands back a response.
module mmio_slot_master #(
    parameter int NUM_SLOTS      = 4,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [31:0]               resp_rdata,
    output logic [1:0]                resp_err,
    output logic [NUM_SLOTS-1:0]      chip_select,
    output logic                      read,
    output logic                      write,
    output logic [7:0]                addr,
    output logic [31:0]               wr_data,
    output logic                      transaction_completed,
    input  logic [NUM_SLOTS*32-1:0]   slot_rd_data,
    input  logic [NUM_SLOTS-1:0]      slot_wr_done,
    input  logic [NUM_SLOTS-1:0]      slot_rd_done,
    input  logic [NUM_SLOTS-1:0]      slot_slave_error,
    input  logic [NUM_SLOTS-1:0]      slot_decode_error
);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_SLAVE   = 2'b01;
    localparam logic [1:0] ERR_DECODE  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE, RESP} state_t;

    state_t               state_q, state_d;
    logic [NUM_SLOTS-1:0] chip_select_q, chip_select_d;
    logic                 read_q, read_d;
    logic                 write_q, write_d;
    logic [7:0]           addr_q, addr_d;
    logic [31:0]          wr_data_q, wr_data_d;
    logic                 transaction_completed_q, transaction_completed_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [31:0]          resp_rdata_q, resp_rdata_d;
    logic [1:0]           resp_err_q, resp_err_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;

    logic [31:0]          req_idx;
    logic                 req_idx_ok;
    logic [NUM_SLOTS-1:0] req_onehot;
    logic [31:0]          sel_rd_data;
    logic                 sel_slave_err;
    logic                 sel_decode_err;
    logic                 sel_done;
    logic                 timed_out;

    assign req_idx    = 32'(req_addr[ADDR_W-1:8]);
    assign req_idx_ok = req_idx < 32'(NUM_SLOTS);
    assign req_onehot = NUM_SLOTS'(1) << req_idx;

    // The registered one-hot chip select doubles as the slot selector for the return path.
    always_comb begin
        sel_rd_data = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (chip_select_q[i]) begin
                sel_rd_data = sel_rd_data | slot_rd_data[32*i +: 32];
            end
        end
    end

    assign sel_slave_err  = |(slot_slave_error & chip_select_q);
    assign sel_decode_err = |(slot_decode_error & chip_select_q);
    assign sel_done       = (state_q == ACCESS) &&
                            (|((slot_wr_done | slot_rd_done) & chip_select_q) ||
                             sel_slave_err || sel_decode_err);
    assign timed_out      = (state_q == ACCESS) && !sel_done &&
                            (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (req_valid) state_d = req_idx_ok ? ACCESS : RESP;
            ACCESS:   if (sel_done || timed_out) state_d = COMPLETE;
            COMPLETE: state_d = RESP;
            RESP:     if (resp_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Every visible output is a flop loaded from the transition being taken this cycle.
    always_comb begin
        chip_select_d           = chip_select_q;
        read_d                  = read_q;
        write_d                 = write_q;
        addr_d                  = addr_q;
        wr_data_d               = wr_data_q;
        timer_d                 = timer_q;
        resp_rdata_d            = resp_rdata_q;
        resp_err_d              = resp_err_q;
        transaction_completed_d = (state_d == COMPLETE);
        resp_valid_d            = (state_d == RESP);
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    timer_d = '0;
                    if (req_idx_ok) begin
                        chip_select_d = req_onehot;
                        read_d        = !req_write;
                        write_d       = req_write;
                        addr_d        = req_addr[7:0];
                        wr_data_d     = req_wdata;
                    end else begin
                        resp_err_d   = ERR_DECODE;
                        resp_rdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                timer_d = timer_q + 1'b1;
                if (sel_done) begin
                    chip_select_d = '0;
                    read_d        = 1'b0;
                    write_d       = 1'b0;
                    resp_err_d    = sel_decode_err ? ERR_DECODE :
                                    sel_slave_err  ? ERR_SLAVE  : ERR_OK;
                    resp_rdata_d  = (read_q && !sel_decode_err && !sel_slave_err) ?
                                    sel_rd_data : '0;
                end else if (timed_out) begin
                    chip_select_d = '0;
                    read_d        = 1'b0;
                    write_d       = 1'b0;
                    resp_err_d    = ERR_TIMEOUT;
                    resp_rdata_d  = '0;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_err_d   = ERR_OK;
                    resp_rdata_d = '0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            chip_select_q           <= '0;
            read_q                  <= 1'b0;
            write_q                 <= 1'b0;
            addr_q                  <= '0;
            wr_data_q               <= '0;
            transaction_completed_q <= 1'b0;
            resp_valid_q            <= 1'b0;
            resp_rdata_q            <= '0;
            resp_err_q              <= '0;
            timer_q                 <= '0;
        end else begin
            chip_select_q           <= chip_select_d;
            read_q                  <= read_d;
            write_q                 <= write_d;
            addr_q                  <= addr_d;
            wr_data_q               <= wr_data_d;
            transaction_completed_q <= transaction_completed_d;
            resp_valid_q            <= resp_valid_d;
            resp_rdata_q            <= resp_rdata_d;
            resp_err_q              <= resp_err_d;
            timer_q                 <= timer_d;
        end
    end

    assign req_ready             = (state_q == IDLE);
    assign chip_select           = chip_select_q;
    assign read                  = read_q;
    assign write                 = write_q;
    assign addr                  = addr_q;
    assign wr_data               = wr_data_q;
    assign transaction_completed = transaction_completed_q;
    assign resp_valid            = resp_valid_q;
    assign resp_rdata            = resp_rdata_q;
    assign resp_err              = resp_err_q;

endmodule

// File: tb/tb_mmio_slot_master.sv
// Bench for mmio_slot_master: directed vector table, randomized transactions against a
// transaction-level reference model, and a reset-during-access sequence.
module tb_mmio_slot_master;
    localparam int NUM_SLOTS = 4;
    localparam int TIMEOUT   = 8;
    localparam int LIMIT     = 40;

    logic         clk;
    logic         arst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [15:0]  req_addr;
    logic [31:0]  req_wdata;
    logic         resp_valid;
    logic         resp_ready;
    logic [31:0]  resp_rdata;
    logic [1:0]   resp_err;
    logic [3:0]   chip_select;
    logic         read;
    logic         write;
    logic [7:0]   addr;
    logic [31:0]  wr_data;
    logic         transaction_completed;
    logic [127:0] slot_rd_data;
    logic [3:0]   slot_wr_done;
    logic [3:0]   slot_rd_done;
    logic [3:0]   slot_slave_error;
    logic [3:0]   slot_decode_error;

    int errors = 0;
    int checks = 0;

    logic        obs_ready_at_req;
    logic        obs_got_resp;
    logic [1:0]  obs_err;
    logic [31:0] obs_rdata;
    int          obs_resp_cyc;
    int          obs_tc_cnt;
    int          obs_tc_cyc;
    int          obs_strobe_cnt;
    int          obs_first_strobe;
    int          obs_strobe_bad;
    int          obs_busy_ready;
    int          obs_stable_bad;
    logic        obs_after_valid;
    logic        obs_ready_after;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mode;
        int          lat;
        logic [31:0] rd;
        int          ready_wait;
        logic [1:0]  exp_err;
        logic [31:0] exp_rdata;
        int          exp_resp_cyc;
    } vec_t;

    vec_t vecs[10];

    mmio_slot_master #(
        .NUM_SLOTS(NUM_SLOTS),
        .ADDR_W(16),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .chip_select(chip_select),
        .read(read),
        .write(write),
        .addr(addr),
        .wr_data(wr_data),
        .transaction_completed(transaction_completed),
        .slot_rd_data(slot_rd_data),
        .slot_wr_done(slot_wr_done),
        .slot_rd_done(slot_rd_done),
        .slot_slave_error(slot_slave_error),
        .slot_decode_error(slot_decode_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: outcome follows only from the slot index, the responder
    // behaviour (mode = {decode, slave, rd_done, wr_done}) and when it answers.
    function automatic void model(input logic wr, input logic [15:0] a, input logic [3:0] mode,
                                  input int lat, input logic [31:0] rd,
                                  output logic [1:0] err, output logic [31:0] rdata,
                                  output int resp_cyc);
        if (int'(a[15:8]) >= NUM_SLOTS) begin
            err = 2'b10; rdata = 32'h0; resp_cyc = 1;
        end else if (mode == 4'b0000 || lat > TIMEOUT) begin
            err = 2'b11; rdata = 32'h0; resp_cyc = TIMEOUT + 2;
        end else begin
            err      = mode[3] ? 2'b10 : (mode[2] ? 2'b01 : 2'b00);
            rdata    = (!wr && err == 2'b00) ? rd : 32'h0;
            resp_cyc = lat + 2;
        end
    endfunction

    task automatic clearSlots();
        slot_rd_data      = '0;
        slot_wr_done      = '0;
        slot_rd_done      = '0;
        slot_slave_error  = '0;
        slot_decode_error = '0;
    endtask

    // Runs one transaction from an idle master; cycle 1 is the cycle after acceptance.
    task automatic applyStimulus(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                                 input logic [3:0] mode, input int lat, input logic [31:0] rd,
                                 input int ready_wait);
        int         sel;
        int         cyc;
        logic [3:0] exp_cs;
        sel    = int'(a[15:8]);
        exp_cs = (sel < NUM_SLOTS) ? (4'b0001 << sel) : 4'b0000;
        obs_tc_cnt = 0; obs_tc_cyc = -1; obs_strobe_cnt = 0; obs_first_strobe = -1;
        obs_strobe_bad = 0; obs_busy_ready = 0; obs_stable_bad = 0;
        @(negedge clk);
        obs_ready_at_req = req_ready;
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = (ready_wait < 0);
        @(negedge clk);
        req_write = ~wr;
        req_addr  = 16'($urandom);
        req_wdata = $urandom;
        cyc = 1;
        while (!resp_valid && cyc < LIMIT) begin
            if (req_ready) obs_busy_ready++;
            if (transaction_completed) begin
                obs_tc_cnt++;
                obs_tc_cyc = cyc;
                if (read || write || chip_select != 4'b0000) obs_strobe_bad++;
            end
            if (chip_select != 4'b0000 || read || write) begin
                if (obs_first_strobe < 0) obs_first_strobe = cyc;
                obs_strobe_cnt++;
                if (chip_select != exp_cs || read != !wr || write != wr ||
                    addr != a[7:0] || wr_data != wd) obs_strobe_bad++;
            end
            slot_rd_data      = {$urandom, $urandom, $urandom, $urandom};
            slot_wr_done      = 4'($urandom) & ~exp_cs;
            slot_rd_done      = 4'($urandom) & ~exp_cs;
            slot_slave_error  = 4'($urandom) & ~exp_cs;
            slot_decode_error = 4'($urandom) & ~exp_cs;
            if (sel < NUM_SLOTS && cyc == lat) begin
                slot_wr_done[sel]        = mode[0];
                slot_rd_done[sel]        = mode[1];
                slot_slave_error[sel]    = mode[2];
                slot_decode_error[sel]   = mode[3];
                slot_rd_data[sel*32 +: 32] = rd;
            end
            @(negedge clk);
            cyc++;
        end
        clearSlots();
        obs_got_resp = resp_valid;
        obs_resp_cyc = cyc;
        obs_err      = resp_err;
        obs_rdata    = resp_rdata;
        for (int w = 0; w < ready_wait; w++) begin
            @(negedge clk);
            if (!resp_valid || resp_err != obs_err || resp_rdata != obs_rdata) obs_stable_bad++;
            if (req_ready) obs_busy_ready++;
            if (transaction_completed) obs_tc_cnt++;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        obs_after_valid = resp_valid;
        obs_ready_after = req_ready;
        resp_ready      = 1'b0;
    endtask

    task automatic checkTxn(input string tag, input logic [15:0] a, input logic [1:0] e_err,
                            input logic [31:0] e_rdata, input int e_cyc);
        logic slotted;
        slotted = int'(a[15:8]) < NUM_SLOTS;
        checkOutput({tag, ".ready_at_req"}, 32'(obs_ready_at_req), 32'h1);
        checkOutput({tag, ".got_resp"},     32'(obs_got_resp), 32'h1);
        checkOutput({tag, ".err"},          32'(obs_err), 32'(e_err));
        checkOutput({tag, ".rdata"},        obs_rdata, e_rdata);
        checkOutput({tag, ".resp_cycle"},   32'(obs_resp_cyc), 32'(e_cyc));
        checkOutput({tag, ".tc_count"},     32'(obs_tc_cnt), slotted ? 32'h1 : 32'h0);
        checkOutput({tag, ".strobe_count"}, 32'(obs_strobe_cnt), slotted ? 32'(e_cyc - 2) : 32'h0);
        checkOutput({tag, ".strobe_bad"},   32'(obs_strobe_bad), 32'h0);
        checkOutput({tag, ".busy_ready"},   32'(obs_busy_ready), 32'h0);
        checkOutput({tag, ".resp_stable"},  32'(obs_stable_bad), 32'h0);
        checkOutput({tag, ".valid_after"},  32'(obs_after_valid), 32'h0);
        checkOutput({tag, ".ready_after"},  32'(obs_ready_after), 32'h1);
        if (slotted) begin
            checkOutput({tag, ".tc_cycle"},     32'(obs_tc_cyc), 32'(e_cyc - 1));
            checkOutput({tag, ".first_strobe"}, 32'(obs_first_strobe), 32'h1);
        end
    endtask

    initial begin
        logic        r_wr;
        logic [15:0] r_addr;
        logic [3:0]  r_mode;
        int          r_lat;
        int          r_wait;
        logic [31:0] r_rd;
        logic [1:0]  m_err;
        logic [31:0] m_rdata;
        int          m_cyc;
        int          leak;

        arst_n     = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        clearSlots();

        //            wr    addr      wdata         mode     lat rd            wait err    rdata          cyc
        vecs[0] = '{1'b1, 16'h0004, 32'h00000002, 4'b0001, 3, 32'h00000000,  0, 2'b00, 32'h00000000,  5};
        vecs[1] = '{1'b0, 16'h0110, 32'h00000000, 4'b0010, 3, 32'h00000001,  0, 2'b00, 32'h00000001,  5};
        vecs[2] = '{1'b1, 16'h0040, 32'h12345678, 4'b1000, 2, 32'h00000000,  0, 2'b10, 32'h00000000,  4};
        vecs[3] = '{1'b0, 16'h0000, 32'h00000000, 4'b0110, 3, 32'hDEADBEEF,  0, 2'b01, 32'h00000000,  5};
        vecs[4] = '{1'b0, 16'h0500, 32'h00000000, 4'b0010, 1, 32'h11111111,  0, 2'b10, 32'h00000000,  1};
        vecs[5] = '{1'b0, 16'h0208, 32'h00000000, 4'b0000, 1, 32'h00000000,  3, 2'b11, 32'h00000000, 10};
        vecs[6] = '{1'b0, 16'h0304, 32'h00000000, 4'b0010, 1, 32'hCAFEF00D, -1, 2'b00, 32'hCAFEF00D,  3};
        vecs[7] = '{1'b1, 16'h03FF, 32'hA5A5A5A5, 4'b0001, 8, 32'h00000000,  2, 2'b00, 32'h00000000, 10};
        vecs[8] = '{1'b0, 16'h0120, 32'h00000000, 4'b0010, 9, 32'h77777777,  0, 2'b11, 32'h00000000, 10};
        vecs[9] = '{1'b1, 16'hFF00, 32'h0000BEEF, 4'b0001, 1, 32'h00000000, -1, 2'b10, 32'h00000000,  1};

        repeat (3) @(negedge clk);
        checkOutput("reset.req_ready",   32'(req_ready), 32'h1);
        checkOutput("reset.chip_select", 32'(chip_select), 32'h0);
        checkOutput("reset.strobes",     32'({read, write, transaction_completed}), 32'h0);
        checkOutput("reset.resp",        32'({resp_valid, resp_err}), 32'h0);
        checkOutput("reset.resp_rdata",  resp_rdata, 32'h0);
        arst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset.req_ready", 32'(req_ready), 32'h1);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].mode,
                          vecs[i].lat, vecs[i].rd, vecs[i].ready_wait);
            checkTxn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_err,
                     vecs[i].exp_rdata, vecs[i].exp_resp_cyc);
        end

        for (int i = 0; i < 40; i++) begin
            r_wr   = 1'($urandom);
            r_addr = 16'($urandom);
            r_addr[15:8] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(4, 255))
                                                       : 8'($urandom_range(0, 3));
            r_mode = 4'($urandom);
            r_lat  = int'($urandom_range(1, 10));
            r_rd   = $urandom;
            r_wait = int'($urandom_range(0, 4)) - 1;
            model(r_wr, r_addr, r_mode, r_lat, r_rd, m_err, m_rdata, m_cyc);
            applyStimulus(r_wr, r_addr, $urandom, r_mode, r_lat, r_rd, r_wait);
            checkTxn($sformatf("rand%0d", i), r_addr, m_err, m_rdata, m_cyc);
        end

        // Reset dropped mid-access must clear everything at once and leave no response behind.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0210;
        req_wdata = 32'h0BADF00D;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid.cs_before", 32'(chip_select), 32'h4);
        #2 arst_n = 1'b0;
        #1;
        checkOutput("rst_mid.cs_async",   32'(chip_select), 32'h0);
        checkOutput("rst_mid.strobes",    32'({read, write, transaction_completed}), 32'h0);
        checkOutput("rst_mid.resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("rst_mid.addr_data",  {addr, 24'h0} | 32'(wr_data != 32'h0), 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        leak = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (resp_valid || transaction_completed || chip_select != 4'b0000) leak++;
        end
        checkOutput("rst_mid.no_response", 32'(leak), 32'h0);
        checkOutput("rst_mid.req_ready",   32'(req_ready), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
